// File: rtl/sm1118_msg_scheduler_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sm1118_msg_scheduler_if
// Purpose  : Bundles the request side (three sources) and the UART message
//            transmitter side of the message scheduler.
// Signals  : req[2:0]          request level per source (0 SI det, 1 pick, 2 deposit)
//            req_payload[23:0] 8 bits per source {msg_type,field,node_si,color}
//            req_ack[2:0]      one-cycle acceptance pulse per source
//            tx_start, msg_type, field, node_si, color -> transmitter
//            tx_complete       done status from the transmitter
//            busy, fifo_full, err_timeout, err_bad_type  status
// Modports : slave  - the scheduler
//            master - the environment (request sources + transmitter)
// Revision : 1.0 - initial release
// ============================================================================
interface sm1118_msg_scheduler_if;
    logic [2:0]  req;
    logic [23:0] req_payload;
    logic [2:0]  req_ack;
    logic        tx_start;
    logic [1:0]  msg_type;
    logic [1:0]  field;
    logic [1:0]  node_si;
    logic [1:0]  color;
    logic        tx_complete;
    logic        busy;
    logic        fifo_full;
    logic        err_timeout;
    logic        err_bad_type;

    modport slave (
        input  req, req_payload, tx_complete,
        output req_ack, tx_start, msg_type, field, node_si, color,
               busy, fifo_full, err_timeout, err_bad_type
    );

    modport master (
        output req, req_payload, tx_complete,
        input  req_ack, tx_start, msg_type, field, node_si, color,
               busy, fifo_full, err_timeout, err_bad_type
    );
endinterface
`default_nettype wire

// File: rtl/sm1118_msg_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sm1118_msg_scheduler
// Purpose  : Round-robin arbiter for three message sources feeding a FIFO,
//            and a sequencer that hands queued messages one at a time to the
//            UART message transmitter with a fixed idle gap between them.
// Ports    : clk_50M - 50 MHz clock
//            rst_n   - asynchronous active-low reset
//            bus     - sm1118_msg_scheduler_if.slave (requests, transmitter
//                      handshake, status flags)
// Params   : FIFO_DEPTH (power of two, >= 2), GAP_CYCLES (>= 1), TIMEOUT
// Revision : 1.0 - initial release
// ============================================================================
module sm1118_msg_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 868,
    parameter int TIMEOUT    = 131071
) (
    input  wire logic             clk_50M,
    input  wire logic             rst_n,
    sm1118_msg_scheduler_if.slave bus
);
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(FIFO_DEPTH);
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP_CYCLES - 1);
    // The watchdog "reaches TIMEOUT" on the edge it would count to TIMEOUT.
    localparam logic [16:0]     c_WD_LAST  = 17'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_CLR  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    state_t            r_state, w_state_next;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [c_PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic [2:0]        r_req_ack;
    logic [1:0]        r_last;
    logic [7:0]        r_out;
    logic              r_tx_start, r_busy, r_err_timeout, r_err_bad_type;
    logic [16:0]       r_wdog;
    logic [c_GW-1:0]   r_gap;

    logic [2:0]        w_elig;
    logic [1:0]        w_o0, w_o1, w_o2, w_gidx;
    logic              w_grant, w_push, w_pop, w_wd_expire, w_set_timeout, w_tx_next;
    logic [7:0]        w_gpay;

    // ---------------- Arbiter ----------------
    // A source whose ack is high this cycle is masked so a held request is
    // not accepted twice; nothing is granted while the queue is full.
    always_comb begin
        w_elig = bus.req & ~r_req_ack;
        if (r_count >= c_DEPTH)
            w_elig = 3'b000;
        case (r_last)
            2'd0:    begin w_o0 = 2'd1; w_o1 = 2'd2; w_o2 = 2'd0; end
            2'd1:    begin w_o0 = 2'd2; w_o1 = 2'd0; w_o2 = 2'd1; end
            default: begin w_o0 = 2'd0; w_o1 = 2'd1; w_o2 = 2'd2; end
        endcase
        w_grant = 1'b1;
        w_gidx  = w_o0;
        if (w_elig[w_o0])      w_gidx = w_o0;
        else if (w_elig[w_o1]) w_gidx = w_o1;
        else if (w_elig[w_o2]) w_gidx = w_o2;
        else                   w_grant = 1'b0;
        case (w_gidx)
            2'd1:    w_gpay = bus.req_payload[15:8];
            2'd2:    w_gpay = bus.req_payload[23:16];
            default: w_gpay = bus.req_payload[7:0];
        endcase
        // msg_type 0 is invalid: acknowledged but never queued.
        w_push = w_grant && (w_gpay[7:6] != 2'b00);
    end

    assign w_pop = (r_state == S_LOAD);

    always_ff @(posedge clk_50M) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_gpay;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ack      <= 3'b000;
            r_last         <= 2'd2;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_err_bad_type <= 1'b0;
        end else begin
            r_req_ack <= 3'b000;
            if (w_grant) begin
                r_req_ack[w_gidx] <= 1'b1;
                r_last            <= w_gidx;
                if (!w_push)
                    r_err_bad_type <= 1'b1;
            end
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- Sequencer ----------------
    always_comb begin
        w_state_next  = r_state;
        w_set_timeout = 1'b0;
        w_wd_expire   = (r_wdog == c_WD_LAST);
        case (r_state)
            S_IDLE:      if (r_count != '0) w_state_next = S_LOAD;
            S_LOAD:      w_state_next = S_START;
            S_START:     w_state_next = S_WAIT_CLR;
            S_WAIT_CLR: begin
                // A done flag left over from the previous message must clear
                // before the new completion can be trusted.
                if (!bus.tx_complete) begin
                    w_state_next = S_WAIT_DONE;
                end else if (w_wd_expire) begin
                    w_state_next  = S_GAP;
                    w_set_timeout = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (bus.tx_complete) begin
                    w_state_next = S_GAP;
                end else if (w_wd_expire) begin
                    w_state_next  = S_GAP;
                    w_set_timeout = 1'b1;
                end
            end
            S_GAP:       if (r_gap == c_GAP_LAST) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
        w_tx_next = (w_state_next == S_START) || (w_state_next == S_WAIT_CLR) ||
                    (w_state_next == S_WAIT_DONE);
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_tx_start    <= 1'b0;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_wdog        <= '0;
            r_gap         <= '0;
            r_out         <= '0;
        end else begin
            r_state    <= w_state_next;
            r_tx_start <= w_tx_next;
            r_busy     <= (w_state_next != S_IDLE);
            if (w_set_timeout)
                r_err_timeout <= 1'b1;
            if (r_state == S_START)
                r_wdog <= '0;
            else if ((r_state == S_WAIT_CLR) || (r_state == S_WAIT_DONE))
                r_wdog <= r_wdog + 1'b1;
            if (r_state == S_GAP)
                r_gap <= r_gap + 1'b1;
            else
                r_gap <= '0;
            if (w_pop)
                r_out <= r_mem[r_rd_ptr];
        end
    end

    assign bus.req_ack      = r_req_ack;
    assign bus.tx_start     = r_tx_start;
    assign bus.msg_type     = r_out[7:6];
    assign bus.field        = r_out[5:4];
    assign bus.node_si      = r_out[3:2];
    assign bus.color        = r_out[1:0];
    assign bus.busy         = r_busy;
    assign bus.fifo_full    = (r_count == c_DEPTH);
    assign bus.err_timeout  = r_err_timeout;
    assign bus.err_bad_type = r_err_bad_type;

endmodule
`default_nettype wire

// File: tb/tb_sm1118_msg_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sm1118_msg_scheduler
// Purpose  : Self-checking bench for sm1118_msg_scheduler: a behavioural
//            queue-based model compared every cycle, plus directed scenarios
//            with hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm1118_msg_scheduler;
    localparam int c_FD  = 4;
    localparam int c_GAP = 868;
    localparam int c_TO  = 300;

    localparam int c_M_IDLE = 0, c_M_LOAD = 1, c_M_START = 2,
                   c_M_CLR  = 3, c_M_DONE = 4, c_M_GAP   = 5;

    logic clk_50M;
    logic rst_n;
    int   n_err = 0;
    int   n_chk = 0;

    sm1118_msg_scheduler_if bus();

    sm1118_msg_scheduler #(
        .FIFO_DEPTH (c_FD),
        .GAP_CYCLES (c_GAP),
        .TIMEOUT    (c_TO)
    ) u_dut (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial begin
        clk_50M = 1'b0;
        forever #5 clk_50M = ~clk_50M;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- Behavioural model ----------------
    logic [7:0] mq[$];
    logic [2:0] m_ack  = 3'b000;
    int         m_last = 2;
    logic [7:0] m_out  = 8'h00;
    int         m_mode = c_M_IDLE;
    int         m_wait = 0;
    int         m_gap  = 0;
    bit         m_to   = 1'b0;
    bit         m_bad  = 1'b0;

    initial begin
        int g, s;
        logic [7:0] p;
        forever begin
            @(posedge clk_50M or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_ack = 3'b000; m_last = 2; m_out = 8'h00; m_mode = c_M_IDLE;
                m_wait = 0; m_gap = 0; m_to = 1'b0; m_bad = 1'b0;
            end else begin
                // grant decided on the queue length before this edge
                g = -1;
                if (mq.size() < c_FD)
                    for (int k = 1; k <= 3; k++) begin
                        s = (m_last + k) % 3;
                        if (g < 0 && bus.req[s] && !m_ack[s]) g = s;
                    end
                case (m_mode)
                    c_M_IDLE:  if (mq.size() > 0) m_mode = c_M_LOAD;
                    c_M_LOAD:  begin m_out = mq.pop_front(); m_mode = c_M_START; end
                    c_M_START: begin m_mode = c_M_CLR; m_wait = 0; end
                    c_M_CLR: begin
                        m_wait++;
                        if (!bus.tx_complete) m_mode = c_M_DONE;
                        else if (m_wait == c_TO) begin m_to = 1'b1; m_mode = c_M_GAP; m_gap = 0; end
                    end
                    c_M_DONE: begin
                        m_wait++;
                        if (bus.tx_complete) begin m_mode = c_M_GAP; m_gap = 0; end
                        else if (m_wait == c_TO) begin m_to = 1'b1; m_mode = c_M_GAP; m_gap = 0; end
                    end
                    default: begin
                        m_gap++;
                        if (m_gap == c_GAP) m_mode = c_M_IDLE;
                    end
                endcase
                m_ack = 3'b000;
                if (g >= 0) begin
                    m_ack[g] = 1'b1;
                    m_last   = g;
                    p        = bus.req_payload[8*g +: 8];
                    if (p[7:6] == 2'b00) m_bad = 1'b1;
                    else                 mq.push_back(p);
                end
            end
        end
    end

    // ---------------- Per-cycle compare ----------------
    logic [15:0] dut_vec, exp_vec;
    assign dut_vec = {bus.req_ack, bus.tx_start, bus.msg_type, bus.field, bus.node_si,
                      bus.color, bus.busy, bus.fifo_full, bus.err_timeout, bus.err_bad_type};
    assign exp_vec = {m_ack, (m_mode == c_M_START || m_mode == c_M_CLR || m_mode == c_M_DONE),
                      m_out, (m_mode != c_M_IDLE), (mq.size() == c_FD), m_to, m_bad};

    initial begin
        forever begin
            @(negedge clk_50M);
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            end
        end
    end

    // ---------------- Transmitter stand-in ----------------
    bit stuck = 1'b0;
    int u_len = 5;
    int u_cnt = 0;
    initial begin
        bus.tx_complete = 1'b1;
        forever begin
            @(negedge clk_50M);
            if (!rst_n) begin
                u_cnt = 0;
                bus.tx_complete = 1'b1;
            end else if (u_cnt > 0) begin
                u_cnt--;
                if (u_cnt == 0) bus.tx_complete = 1'b1;
            end else if (!stuck && bus.tx_start && bus.tx_complete) begin
                bus.tx_complete = 1'b0;
                u_cnt = u_len;
            end
        end
    end

    // ---------------- Logs ----------------
    logic [7:0] txlog[$];
    int         ack_src[$];
    int         ack_cyc[$];
    int         cyc = 0;
    initial forever begin @(posedge clk_50M); cyc++; end

    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk_50M);
            if (bus.tx_start && !prev)
                txlog.push_back({bus.msg_type, bus.field, bus.node_si, bus.color});
            prev = bus.tx_start;
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic post(input logic [2:0] mask, input logic [23:0] pay, input int limit);
        int n = 0;
        bus.req_payload = pay;
        bus.req         = mask;
        while (bus.req != 3'b000 && n < limit) begin
            @(negedge clk_50M);
            n++;
            for (int i = 0; i < 3; i++)
                if (bus.req_ack[i] && bus.req[i]) begin
                    bus.req[i] = 1'b0;
                    ack_src.push_back(i);
                    ack_cyc.push_back(cyc);
                end
        end
        if (bus.req != 3'b000) begin
            chk("post_ack_wait", 32'(bus.req), 32'h0);
            bus.req = 3'b000;
        end
    endtask

    task automatic wait_tx(input logic lvl, input int limit, input string nm);
        int n = 0;
        while (bus.tx_start !== lvl && n < limit) begin
            @(negedge clk_50M);
            n++;
        end
        chk(nm, 32'(bus.tx_start), 32'(lvl));
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (bus.busy && n < limit) begin
            @(negedge clk_50M);
            n++;
        end
        chk("busy_idle", 32'(bus.busy), 32'h0);
    endtask

    task automatic wait_log(input int cnt, input int limit);
        int n = 0;
        while (txlog.size() < cnt && n < limit) begin
            @(negedge clk_50M);
            n++;
        end
        chk("txlog_count", 32'(txlog.size()), 32'(cnt));
    endtask

    task automatic do_reset();
        @(negedge clk_50M);
        rst_n   = 1'b0;
        bus.req = 3'b000;
        repeat (2) @(negedge clk_50M);
        rst_n = 1'b1;
        txlog.delete();
        ack_src.delete();
        ack_cyc.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_time_limit t=%0t", $time);
        $fatal(1, "time limit");
    end

    // ---------------- Directed scenarios ----------------
    initial begin
        int k;
        rst_n           = 1'b0;
        bus.req         = 3'b000;
        bus.req_payload = 24'h0;
        repeat (3) @(negedge clk_50M);
        chk("reset_state", 32'(dut_vec), 32'h0);
        rst_n = 1'b1;
        @(negedge clk_50M);

        // Single request from source 1
        post(3'b010, {8'h00, 8'hB6, 8'h00}, 10);
        chk("single_ack_src", 32'(ack_src[0]), 32'd1);
        wait_tx(1'b1, 20, "single_tx_rise");
        chk("single_fields", {24'h0, bus.msg_type, bus.field, bus.node_si, bus.color}, 32'hB6);
        wait_tx(1'b0, 200, "single_tx_fall");
        k = 0;
        while (bus.busy && k < 2000) begin @(negedge clk_50M); k++; end
        chk("gap_len", k, 868);

        // Simultaneous requests after reset: 0,1,2 on consecutive cycles
        do_reset();
        post(3'b111, {8'h6B, 8'h56, 8'h41}, 10);
        chk("rr_order", {ack_src[0][7:0], ack_src[1][7:0], ack_src[2][7:0]}, 32'h00_0102);
        chk("rr_consec", {ack_cyc[1] - ack_cyc[0], ack_cyc[2] - ack_cyc[1]}, {32'd1, 32'd1});
        wait_log(3, 4000);
        chk("rr_tx_order", {8'h0, txlog[0], txlog[1], txlog[2]}, 32'h00_41566B);
        wait_idle(2000);

        // Fill the queue while the first message waits for completion
        do_reset();
        u_len = 40;
        post(3'b001, {16'h0, 8'h81}, 10);
        k = 0;
        while (!(bus.tx_start && !bus.tx_complete) && k < 30) begin @(negedge clk_50M); k++; end
        chk("fill_in_flight", 32'(bus.tx_start), 32'h1);
        post(3'b010, {8'h00, 8'h92, 8'h00}, 10);
        post(3'b100, {8'hA3, 8'h00, 8'h00}, 10);
        post(3'b001, {8'h00, 8'h00, 8'hB0}, 10);
        post(3'b010, {8'h00, 8'hC5, 8'h00}, 10);
        chk("fifo_full_after4", 32'(bus.fifo_full), 32'h1);
        bus.req_payload = {8'hD6, 16'h0};
        bus.req         = 3'b100;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_50M);
            if (bus.req_ack[2]) k++;
        end
        chk("no_ack_while_full", k, 0);
        post(3'b100, {8'hD6, 16'h0}, 3000);
        wait_log(6, 8000);
        chk("fifth_sent", 32'(txlog[5]), 32'hD6);
        wait_idle(2000);
        u_len = 5;

        // Invalid message type
        do_reset();
        post(3'b100, {8'h3F, 16'h0}, 10);
        chk("bad_type_flag", 32'(bus.err_bad_type), 32'h1);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_50M);
            if (bus.tx_start || bus.busy) k++;
        end
        chk("bad_type_no_tx", k, 0);

        // Watchdog: done stays high, message dropped, next one proceeds
        do_reset();
        stuck = 1'b1;
        post(3'b011, {8'h00, 8'h7A, 8'h55}, 10);
        wait_tx(1'b1, 20, "to_tx_rise");
        k = 0;
        while (bus.tx_start && k < 2000) begin @(negedge clk_50M); k++; end
        chk("to_tx_high_len", k, 301);
        chk("to_flag", 32'(bus.err_timeout), 32'h1);
        stuck = 1'b0;
        wait_log(2, 2000);
        chk("to_next_msg", 32'(txlog[1]), 32'h7A);
        wait_idle(2000);

        // Reset in the middle of a transmission with two queued
        do_reset();
        u_len = 40;
        post(3'b001, {16'h0, 8'h41}, 10);
        wait_tx(1'b1, 20, "rst_tx_rise");
        k = 0;
        while (bus.tx_complete && k < 10) begin @(negedge clk_50M); k++; end
        post(3'b110, {8'h63, 8'h52, 8'h00}, 10);
        chk("rst_pre_tx", 32'(bus.tx_start), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {29'h0, bus.tx_start, bus.busy, bus.fifo_full}, 32'h0);
        repeat (2) @(negedge clk_50M);
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk_50M);
            if (bus.tx_start) k++;
        end
        chk("rst_no_resend", k, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
